// File: rtl/bram_rr_arbiter_pkg.sv
// Shared types and helpers for the BRAM round-robin arbiter.
package bram_rr_arbiter_pkg;

  // Arbiter states: IDLE arbitrates freely, LOCK holds the port for a burst owner.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Number of bits needed to index 'value' distinct items (minimum 1).
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_priority_select.sv
// Rotating priority picker: first asserted request at or after ptr, wrapping at NUM_REQ-1.
module rr_priority_select #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  // Walk ptr, ptr+1, ... modulo NUM_REQ and keep the first hit.
  always_comb begin
    int idx;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_idx     = ID_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous BRAM port among NUM_REQ requesters,
// with locked bursts and in-order read-data routing back to the issuing requester.
module bram_rr_arbiter
  import bram_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             arb_en,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             mem_wr,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic [DATA_WIDTH-1:0]            mem_data_out
);

  localparam int ID_W = clog2_f(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         owner_q, owner_d;

  logic [NUM_REQ-1:0]      sel_req;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_any;

  logic [NUM_REQ-1:0]      grant_oh;
  logic [ID_W-1:0]         grant_idx;
  logic                    xfer;

  logic [RD_LATENCY-1:0]   rd_vld_q, rd_vld_d;
  logic [ID_W-1:0]         rd_id_q [RD_LATENCY];
  logic [ID_W-1:0]         rd_id_d [RD_LATENCY];

  // Successor of a requester index, wrapping at NUM_REQ-1 even for non power-of-two counts.
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  // Free arbitration only happens in IDLE with arbitration enabled.
  always_comb begin
    sel_req = '0;
    if (state_q == ST_IDLE && arb_en) sel_req = req_valid;
  end

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_select (
    .req       (sel_req),
    .ptr       (ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Grant: the burst owner while locked (only when it is valid), otherwise the rotating pick.
  always_comb begin
    grant_idx = pick_idx;
    grant_oh  = '0;
    if (state_q == ST_LOCK) begin
      grant_idx = owner_q;
      if (req_valid[owner_q]) grant_oh[owner_q] = 1'b1;
    end else if (pick_any) begin
      grant_oh = pick_oh;
    end
    if (!rst_n) grant_oh = '0;
    xfer = |grant_oh;
  end

  assign req_ready   = grant_oh;
  assign mem_wr      = xfer & req_wr[grant_idx];
  assign mem_addr    = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_data_in = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign rsp_data    = mem_data_out;

  // Next arbitration state: every transfer advances ptr past the grantee; a non-final beat locks.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      ptr_d   = inc_id(grant_idx);
      owner_d = grant_idx;
      state_d = req_last[grant_idx] ? ST_IDLE : ST_LOCK;
    end
  end

  // Response tags: reads enter at stage 0 and emerge RD_LATENCY cycles later, in issue order.
  always_comb begin
    rd_vld_d    = '0;
    rd_id_d     = rd_id_q;
    rd_vld_d[0] = xfer & ~req_wr[grant_idx];
    rd_id_d[0]  = grant_idx;
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_vld_d[k] = rd_vld_q[k-1];
      rd_id_d[k]  = rd_id_q[k-1];
    end
  end

  // Decode the oldest tag into the one-hot read-data strobe.
  always_comb begin
    rsp_valid = '0;
    if (rd_vld_q[RD_LATENCY-1]) rsp_valid[rd_id_q[RD_LATENCY-1]] = 1'b1;
  end

  // Control state and response valids; reset drops any lock and every pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      rd_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Requester IDs ride alongside the valids; they are meaningless without a valid.
  always_ff @(posedge clk) begin
    rd_id_q <= rd_id_d;
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: two instances (read latency 1 and 3) on shared stimulus,
// each with its own BRAM model, checked every cycle against a behavioural model.
module tb_bram_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic              clk;
  logic              rst_n;
  logic              arb_en;
  logic [N-1:0]      req_valid, req_wr, req_last;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;

  logic [N-1:0]      ready1, rv1, ready3, rv3;
  logic [DW-1:0]     rdat1, rdat3, mdi1, mdi3, mdo1, mdo3;
  logic [AW-1:0]     maddr1, maddr3;
  logic              mwr1, mwr3;

  int checks   = 0;
  int failures = 0;

  bram_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_ready(ready1),
    .req_wr(req_wr), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rv1), .rsp_data(rdat1), .mem_wr(mwr1), .mem_addr(maddr1),
    .mem_data_in(mdi1), .mem_data_out(mdo1));

  bram_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_ready(ready3),
    .req_wr(req_wr), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rv3), .rsp_data(rdat3), .mem_wr(mwr3), .mem_addr(maddr3),
    .mem_data_in(mdi3), .mem_data_out(mdo3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM models: latency 1 and latency 3, read-before-write.
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] rd3 [3];
  always @(posedge clk) begin
    if (mwr1) mem1[maddr1] <= mdi1;
    mdo1 <= mem1[maddr1];
    if (mwr3) mem3[maddr3] <= mdi3;
    rd3[0] <= mem3[maddr3];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mdo3 = rd3[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
    bit          known;
  } rsp_t;

  rsp_t        q1[$];
  rsp_t        q3[$];
  logic [31:0] gold [1024];
  bit          known [1024];
  bit          m_locked = 1'b0;
  int          m_ptr    = 0;
  int          m_owner  = 0;
  int          cyc      = 0;

  always @(negedge clk) begin
    int          g;
    logic [N-1:0] er, ev1, ev3;
    logic [31:0] ed1, ed3;
    bit          dk1, dk3;
    logic [9:0]  ga;
    logic [31:0] gd;
    cyc = cyc + 1;
    g = -1; er = '0; ev1 = '0; ev3 = '0; ed1 = '0; ed3 = '0; dk1 = 0; dk3 = 0;
    ga = '0; gd = '0;
    if (!rst_n) begin
      m_locked = 1'b0; m_ptr = 0; m_owner = 0;
      q1.delete(); q3.delete();
    end else begin
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else if (arb_en) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) er[g] = 1'b1;
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      ev1[q1[0].id] = 1'b1; ed1 = q1[0].data; dk1 = q1[0].known; void'(q1.pop_front());
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      ev3[q3[0].id] = 1'b1; ed3 = q3[0].data; dk3 = q3[0].known; void'(q3.pop_front());
    end
    chk("req_ready_l1", 64'(ready1), 64'(er));
    chk("req_ready_l3", 64'(ready3), 64'(er));
    chk("mem_wr_l1", 64'(mwr1), 64'((g >= 0) ? req_wr[g] : 1'b0));
    chk("mem_wr_l3", 64'(mwr3), 64'((g >= 0) ? req_wr[g] : 1'b0));
    if (g >= 0) begin
      ga = req_addr[g*AW +: AW];
      gd = req_data[g*DW +: DW];
      chk("mem_addr_l1", 64'(maddr1), 64'(ga));
      chk("mem_addr_l3", 64'(maddr3), 64'(ga));
      chk("mem_data_in_l1", 64'(mdi1), 64'(gd));
      chk("mem_data_in_l3", 64'(mdi3), 64'(gd));
    end
    chk("rsp_valid_l1", 64'(rv1), 64'(ev1));
    chk("rsp_valid_l3", 64'(rv3), 64'(ev3));
    if (ev1 != '0 && dk1) chk("rsp_data_l1", 64'(rdat1), 64'(ed1));
    if (ev3 != '0 && dk3) chk("rsp_data_l3", 64'(rdat3), 64'(ed3));
    if (g >= 0) begin
      m_ptr    = (g + 1) % N;
      m_owner  = g;
      m_locked = !req_last[g];
      if (req_wr[g]) begin
        gold[ga]  = gd;
        known[ga] = 1'b1;
      end else begin
        q1.push_back('{cyc + 1, g, gold[ga], known[ga]});
        q3.push_back('{cyc + 3, g, gold[ga], known[ga]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit wr, input bit last,
                         input logic [9:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_wr[i]            = wr;
    req_last[i]          = last;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req_valid = '0; req_wr = '0; req_last = '1; req_addr = '0; req_data = '0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt [N];
    rst_n  = 1'b0;
    arb_en = 1'b1;
    clear_all();
    step();
    #2 chk("reset_ready", 64'(ready1), 64'(0));
    chk("reset_rsp_valid", 64'(rv1), 64'(0));
    chk("reset_mem_wr", 64'(mwr1), 64'(0));
    step();
    rst_n = 1'b1;

    // Requester 2 writes 0xA5 to addr 5, then reads it back.
    step();
    set_req(2, 1, 1, 1, 10'd5, 32'hA5);
    #2 chk("t1_wr_ready", 64'(ready1), 64'h4);
    chk("t1_wr_mem_wr", 64'(mwr1), 64'h1);
    step();
    set_req(2, 1, 0, 1, 10'd5, 32'h0);
    #2 chk("t1_rd_ready", 64'(ready1), 64'h4);
    chk("t1_rd_mem_wr", 64'(mwr1), 64'h0);
    step();
    clear_all();
    #2 chk("t1_rsp_valid", 64'(rv1), 64'h4);
    chk("t1_rsp_data", 64'(rdat1), 64'hA5);

    // All four requesting single-beat reads from ptr=0: strict rotation.
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 1, 0, 1, 10'(i), 32'h0);
      cnt[i] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      #2 chk("t2_rotation", 64'(ready1), 64'(1 << (k % N)));
      for (int i = 0; i < N; i++) if (ready1[i]) cnt[i]++;
      step();
    end
    for (int i = 0; i < N; i++) chk("t2_fairness", 64'(cnt[i]), 64'(2));
    clear_all();

    // Requester 1 bursts three beats while 0 and 3 wait.
    do_reset();
    set_req(0, 1, 0, 1, 10'd1, 32'h0);
    #2 chk("t3_pre", 64'(ready1), 64'h1);
    step();
    set_req(0, 1, 0, 1, 10'd2, 32'h0);
    set_req(3, 1, 0, 1, 10'd3, 32'h0);
    for (int b = 0; b < 3; b++) begin
      set_req(1, 1, 0, b == 2, 10'(8 + b), 32'h0);
      #2 chk("t3_burst_ready", 64'(ready1), 64'h2);
      step();
    end
    set_req(1, 0, 0, 1, 10'd0, 32'h0);
    #2 chk("t3_after_burst", 64'(ready1), 64'h8);
    step();
    set_req(3, 0, 0, 1, 10'd0, 32'h0);
    #2 chk("t3_then_0", 64'(ready1), 64'h1);
    step();
    clear_all();

    // Burst owner 2 stalls for two cycles; lock is held through the bubbles.
    set_req(2, 1, 1, 0, 10'd7, 32'h77);
    set_req(0, 1, 0, 1, 10'd7, 32'h0);
    #2 chk("t4_first", 64'(ready1), 64'h4);
    step();
    set_req(2, 0, 1, 0, 10'd7, 32'h0);
    for (int b = 0; b < 2; b++) begin
      #2 chk("t4_bubble_ready", 64'(ready1), 64'h0);
      chk("t4_bubble_mem_wr", 64'(mwr1), 64'h0);
      step();
    end
    set_req(2, 1, 1, 1, 10'd7, 32'h78);
    #2 chk("t4_last", 64'(ready1), 64'h4);
    step();
    set_req(2, 0, 0, 1, 10'd0, 32'h0);
    #2 chk("t4_released", 64'(ready1), 64'h1);
    step();
    clear_all();

    // arb_en=0 blocks new grants but lets a locked owner finish.
    arb_en = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 1, 10'd7, 32'h0);
    for (int b = 0; b < 2; b++) begin
      #2 chk("t5_disabled", 64'(ready1), 64'h0);
      step();
    end
    clear_all();
    arb_en = 1'b1;
    set_req(1, 1, 0, 0, 10'd7, 32'h0);
    #2 chk("t5_lock_grant", 64'(ready1), 64'h2);
    step();
    arb_en = 1'b0;
    set_req(1, 1, 0, 1, 10'd7, 32'h0);
    set_req(0, 1, 0, 1, 10'd7, 32'h0);
    #2 chk("t5_owner_completes", 64'(ready1), 64'h2);
    step();
    set_req(1, 0, 0, 1, 10'd0, 32'h0);
    #2 chk("t5_no_new_grant", 64'(ready1), 64'h0);
    step();
    arb_en = 1'b1;
    clear_all();

    // Reset shortly after reads on the latency-3 instance drops their responses.
    do_reset();
    set_req(0, 1, 0, 1, 10'd5, 32'h0);
    step();
    set_req(0, 0, 0, 1, 10'd0, 32'h0);
    set_req(1, 1, 0, 1, 10'd7, 32'h0);
    step();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 1, 10'd5, 32'h0);
    #2 chk("t6_reset_wins", 64'(ready3), 64'h0);
    chk("t6_rsp_in_reset", 64'(rv3), 64'h0);
    step();
    rst_n = 1'b1;
    clear_all();
    for (int b = 0; b < 4; b++) begin
      #2 chk("t6_no_stale_rsp", 64'(rv3), 64'h0);
      step();
    end
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 1, 10'd5, 32'h0);
    #2 chk("t6_ptr_zero", 64'(ready3), 64'h1);
    step();
    clear_all();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      arb_en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 7, 10'($urandom_range(0, 15)), $urandom);
    end
    rst_n = 1'b1;
    clear_all();
    for (int b = 0; b < 6; b++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
